// File: rtl/scene_pkg.sv
// Shared scene geometry, address type and a shift-add row-base helper.
package scene_pkg;

    localparam int unsigned SCENE_W      = 320;
    localparam int unsigned SCENE_H      = 240;
    localparam int unsigned SCENE_ADDR_W = 17;
    localparam int unsigned INDEX_W      = 4;
    localparam int unsigned SCROLL_W     = 9;

    typedef logic [SCENE_ADDR_W-1:0] scene_addr_t;

    // sy * w as a sum of shifted copies of sy; w is a constant at every call site.
    function automatic scene_addr_t row_base(input logic [8:0] sy, input int unsigned w);
        scene_addr_t acc;
        acc = '0;
        for (int i = 0; i < int'(SCENE_ADDR_W); i++) begin
            if (w[i]) begin
                acc = acc + (scene_addr_t'(sy) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/scene_scroll_ctrl.sv
// Horizontal scroll offset register with modulo-width wrap, updated once per frame.
// Scrolling is compiled in only when SCENE_SCROLL_EN is defined; otherwise scroll stays 0.
module scene_scroll_ctrl
    import scene_pkg::*;
#(
    parameter int unsigned W = scene_pkg::SCENE_W
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  logic [3:0]          scroll_step,
    input  logic                scroll_dir,
    output logic [SCROLL_W-1:0] scroll
);

`ifdef SCENE_SCROLL_EN
    localparam logic [SCROLL_W:0] WIDTH = (SCROLL_W + 1)'(W);

    logic [SCROLL_W-1:0] scroll_d;
    logic [SCROLL_W:0]   sum;
    logic [SCROLL_W:0]   diff;

    // Both operands stay below W, so one conditional correction is enough.
    always_comb begin
        sum  = {1'b0, scroll} + (SCROLL_W + 1)'(scroll_step);
        diff = {1'b0, scroll} - (SCROLL_W + 1)'(scroll_step);
        if (!scroll_dir) begin
            scroll_d = (sum >= WIDTH) ? SCROLL_W'(sum - WIDTH) : sum[SCROLL_W-1:0];
        end else begin
            scroll_d = diff[SCROLL_W] ? SCROLL_W'(diff + WIDTH) : diff[SCROLL_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            scroll <= '0;
        end else if (frame_start) begin
            scroll <= scroll_d;
        end
    end
`else
    logic unused_scroll_inputs;
    assign unused_scroll_inputs = ^{Clk, Reset_n, frame_start, scroll_step, scroll_dir};
    assign scroll = '0;
`endif

endmodule

// File: rtl/scene_index_fetch.sv
// 2x-upscaled, horizontally scrolled scene ROM fetch: draw coordinate to palette index in 3 cycles.
// Optional scrolling is enabled with the SCENE_SCROLL_EN macro (see scene_scroll_ctrl).
module scene_index_fetch #(
    parameter int unsigned SCENE_W = scene_pkg::SCENE_W,
    parameter int unsigned SCENE_H = scene_pkg::SCENE_H,
    parameter int unsigned LAT     = 3
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic                              frame_start,
    input  logic [3:0]                        scroll_step,
    input  logic                              scroll_dir,
    input  logic                              draw_en,
    input  logic [9:0]                        draw_x,
    input  logic [9:0]                        draw_y,
    output logic [scene_pkg::SCENE_ADDR_W-1:0] rom_addr,
    input  logic [scene_pkg::INDEX_W-1:0]      rom_data,
    output logic [scene_pkg::INDEX_W-1:0]      index,
    output logic                              index_valid
);

    localparam logic [9:0] WIDTH = 10'(SCENE_W);

    logic [8:0]             scroll;
    logic [8:0]             sx;
    logic [8:0]             sy;
    logic [9:0]             col_sum;
    logic [8:0]             cx;
    scene_pkg::scene_addr_t addr_d;
    logic [2:0]             valid_q;
    logic                   unused_lsb;

    scene_scroll_ctrl #(
        .W (SCENE_W)
    ) u_scroll (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .scroll_step (scroll_step),
        .scroll_dir  (scroll_dir),
        .scroll      (scroll)
    );

    assign sx         = draw_x[9:1];
    assign sy         = draw_y[9:1];
    assign unused_lsb = ^{draw_x[0], draw_y[0]};

    always_comb begin
        col_sum = {1'b0, sx} + {1'b0, scroll};
        cx      = (col_sum >= WIDTH) ? 9'(col_sum - WIDTH) : col_sum[8:0];
        addr_d  = scene_pkg::row_base(sy, SCENE_W) + scene_pkg::scene_addr_t'(cx);
    end

    // Stage 1 registers the address, the ROM supplies stage 2, stage 3 captures the index.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            valid_q  <= '0;
            index    <= '0;
        end else begin
            rom_addr <= addr_d;
            valid_q  <= {valid_q[1:0], draw_en};
            index    <= valid_q[1] ? rom_data : '0;
        end
    end

    assign index_valid = valid_q[2];

endmodule

// File: doc/scene_index_fetch.md
SCENE_INDEX_FETCH -- requirements
Module: scene_index_fetch

Interface
REQ-001 SHALL have parameters: SCENE_W, default 320, stored scene width in pixels; SCENE_H, default 240, stored scene height; LAT, fixed 3, draw-to-index latency (informational).
REQ-002 SHALL have port Clk, input, 1, system clock (pixel clock domain).
REQ-003 SHALL have port Reset_n, input, 1; reset is synchronous and active-low; single clock.
REQ-004 SHALL have port frame_start, input, 1, one-cycle pulse at start of vertical blank.
REQ-005 SHALL have port scroll_step, input, 4, pixels advanced per frame.
REQ-006 SHALL have port scroll_dir, input, 1: 0 = scroll left (offset increases), 1 = scroll right.
REQ-007 SHALL have port draw_en, input, 1, active-video qualifier.
REQ-008 SHALL have ports draw_x and draw_y, input, 10 each, screen coordinate 0..639 / 0..479.
REQ-009 SHALL have port rom_addr, output, 17, synchronous scene ROM address.
REQ-010 SHALL have port rom_data, input, 4, ROM word, valid one cycle after rom_addr.
REQ-011 SHALL have port index, output, 4, palette index to the downstream palette lookup.
REQ-012 SHALL have port index_valid, output, 1, index corresponds to an active pixel.

Function
REQ-013 SHALL upscale 2x: sx = draw_x>>1, sy = draw_y>>1.
REQ-014 SHALL compute column cx = (sx + scroll) mod SCENE_W, with no division (single conditional subtract, since both terms < SCENE_W).
REQ-015 SHALL compute rom_addr = sy*SCENE_W + cx using shift-add only (320 = 256+64); maximum 76799 fits 17 bits.
REQ-016 SHALL register rom_addr at edge E1 after draw_x/draw_y sampling (stage 1).
REQ-017 SHALL capture rom_data into index at edge E3, giving a total latency of 3 cycles.
REQ-018 SHALL delay draw_en through a 3-deep valid shift register to produce index_valid, aligned with index.
REQ-019 SHALL force index = 0 in any cycle where index_valid = 0.
REQ-020 SHALL hold scroll as a 9-bit register in 0..SCENE_W-1.
REQ-021 SHALL update scroll only on frame_start: left gives scroll+step, wrapping by subtracting SCENE_W when the sum is >= SCENE_W; right gives scroll-step, adding SCENE_W when the result would be negative.
REQ-022 SHALL apply a new scroll value to draw coordinates sampled from the cycle after the frame_start edge; pixels already in the pipeline keep the old value.
REQ-023 SHALL treat step = 0 as a no-op, scroll unchanged.
REQ-024 SHALL let frame_start coincident with draw_en perform the update normally; no error and no stall.
REQ-025 SHALL have no backpressure: one pixel is accepted every cycle.

Reset
REQ-026 SHALL, on Reset_n = 0 at a Clk edge, set scroll = 0, rom_addr = 0, index = 0, index_valid = 0 and clear the valid pipeline.
REQ-027 SHALL discard in-flight pixels on reset mid-frame; the first valid output appears 3 cycles after the first draw_en = 1 sampled with Reset_n = 1.

Configuration
REQ-028 SHALL gate scrolling with macro SCENE_SCROLL_EN: when defined, behaviour is per REQ-020..024.
REQ-029 SHALL, when SCENE_SCROLL_EN is undefined, hold scroll constant at 0, ignore frame_start, scroll_step and scroll_dir, and leave latency unchanged.

Structure
REQ-030 SHALL take SCENE_W, SCENE_H, SCENE_ADDR_W = 17, INDEX_W = 4 and a scene_addr_t typedef from shared package scene_pkg.
REQ-031 SHALL place the scroll register and wrap logic in sub-module scene_scroll_ctrl (ports Clk, Reset_n, frame_start, scroll_step, scroll_dir, scroll[8:0]).

Verification
REQ-032 SHALL cover: reset, then draw_x = 0, draw_y = 0, draw_en = 1 -> rom_addr = 0 after 1 cycle, index_valid = 1 exactly 3 cycles later, with index = rom_data.
REQ-033 SHALL cover: draw_x = 639, draw_y = 479, scroll = 0 -> rom_addr = 76799.
REQ-034 SHALL cover: scroll = 310, step = 15, dir = 0, frame_start -> scroll = 5; then draw_x = 20, draw_y = 0 -> rom_addr = 15.
REQ-035 SHALL cover: scroll = 3, step = 7, dir = 1, frame_start -> scroll = 316.
REQ-036 SHALL cover: draw_en toggling 1,0,1 -> index_valid toggles 1,0,1 three cycles later, with index = 0 in the invalid cycle.
REQ-037 SHALL cover: Reset_n low for 1 cycle mid-line -> index_valid = 0 for the next 3 cycles, then resumes; also a build without SCENE_SCROLL_EN where frame_start with step = 9 leaves rom_addr unchanged.
